tdm_demux_1x16: RTL and testbench

Time-division demultiplexer that reassembles a serial channel-scanned bit stream into a 16-bit parallel word. The stream is one bit per channel per valid cycle, channel 0 first, as produced by the 16:1 channel-select multiplexer on the transmit side of the link. The block tracks the frame with a channel counter and a sync marker. It presents each completed frame on a registered valid/ready output and reports sticky framing and overrun errors.

---
 rtl/tdm_demux_1x16.sv | 171 +++++++++++++++++
 tb/tb_tdm_demux_1x16.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_1x16.sv
// Reassembles a channel-scanned serial stream into 16-bit frames with sync tracking.
// Optional even-parity 17th bit per frame is enabled by defining DEMUX_PARITY_EN.
module tdm_demux_1x16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        in_bit,
    input  logic        in_sync,
    output logic [3:0]  ch_idx,
    output logic [15:0] out_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        sync_err,
    output logic        overrun,
    output logic        parity_err,
    input  logic        clr_err
);

    localparam int unsigned NCH = 16;
`ifdef DEMUX_PARITY_EN
    localparam int unsigned CNT_W    = 5;
    localparam int unsigned LAST_POS = 16;
`else
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned LAST_POS = 15;
`endif

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        RECV  = 2'd1,
        ALIGN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [NCH-1:0]     asm_q, asm_d;
    logic [NCH-1:0]     out_word_q, out_word_d;
    logic               out_valid_q, out_valid_d;
    logic               sync_err_q, sync_err_d;
    logic               overrun_q, overrun_d;
    logic               sync_ev, ovr_ev, frame_done;
    logic [NCH-1:0]     frame_word;
`ifdef DEMUX_PARITY_EN
    logic               parity_err_q, parity_err_d;
    logic               par_ev;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            count_q      <= '0;
            asm_q        <= '0;
            out_word_q   <= '0;
            out_valid_q  <= 1'b0;
            sync_err_q   <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef DEMUX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            asm_q        <= asm_d;
            out_word_q   <= out_word_d;
            out_valid_q  <= out_valid_d;
            sync_err_q   <= sync_err_d;
            overrun_q    <= overrun_d;
`ifdef DEMUX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Next-state, frame assembly, output handshake and sticky flags
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        asm_d       = asm_q;
        out_word_d  = out_word_q;
        out_valid_d = out_valid_q & ~out_ready;
        sync_ev     = 1'b0;
        ovr_ev      = 1'b0;
        frame_done  = 1'b0;
        frame_word  = asm_q;
`ifdef DEMUX_PARITY_EN
        par_ev      = 1'b0;
`endif

        case (state_q)
            HUNT: begin
                if (in_valid && in_sync) begin
                    asm_d   = NCH'(in_bit);
                    count_d = CNT_W'(1);
                    state_d = RECV;
                end
            end
            RECV: begin
                if (in_valid) begin
                    if (in_sync) begin
                        // Early sync: drop the partial frame and restart at channel 0
                        sync_ev = 1'b1;
                        asm_d   = NCH'(in_bit);
                        count_d = CNT_W'(1);
                    end else if (count_q == CNT_W'(LAST_POS)) begin
                        count_d = '0;
                        state_d = ALIGN;
`ifdef DEMUX_PARITY_EN
                        frame_word = asm_q;
                        if (^{asm_q, in_bit}) begin
                            par_ev = 1'b1;
                        end else begin
                            frame_done = 1'b1;
                        end
`else
                        frame_word = {in_bit, asm_q[NCH-2:0]};
                        frame_done = 1'b1;
`endif
                    end else begin
                        asm_d[count_q[3:0]] = in_bit;
                        count_d             = count_q + CNT_W'(1);
                    end
                end
            end
            ALIGN: begin
                if (in_valid) begin
                    if (in_sync) begin
                        asm_d   = NCH'(in_bit);
                        count_d = CNT_W'(1);
                        state_d = RECV;
                    end else begin
                        sync_ev = 1'b1;
                        state_d = HUNT;
                    end
                end
            end
            default: begin
                state_d = HUNT;
                count_d = '0;
            end
        endcase

        // A frame may load if the slot is empty or being consumed this cycle
        if (frame_done) begin
            if (!out_valid_q || out_ready) begin
                out_word_d  = frame_word;
                out_valid_d = 1'b1;
            end else begin
                ovr_ev = 1'b1;
            end
        end

        sync_err_d   = sync_ev | (sync_err_q & ~clr_err);
        overrun_d    = ovr_ev  | (overrun_q  & ~clr_err);
`ifdef DEMUX_PARITY_EN
        parity_err_d = par_ev  | (parity_err_q & ~clr_err);
`endif
    end

    assign ch_idx    = count_q[3:0];
    assign out_word  = out_word_q;
    assign out_valid = out_valid_q;
    assign sync_err  = sync_err_q;
    assign overrun   = overrun_q;
`ifdef DEMUX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux_1x16.sv
// Directed bench for tdm_demux_1x16: frame table plus hand-written corner sequences.
module tb_tdm_demux_1x16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_bit;
    logic        in_sync;
    logic [3:0]  ch_idx;
    logic [15:0] out_word;
    logic        out_valid;
    logic        out_ready;
    logic        sync_err;
    logic        overrun;
    logic        parity_err;
    logic        clr_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] word;
        int          gap;
        logic [15:0] exp_word;
    } vec_t;

    vec_t vecs [6];

    tdm_demux_1x16 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .in_sync    (in_sync),
        .ch_idx     (ch_idx),
        .out_word   (out_word),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sync_err   (sync_err),
        .overrun    (overrun),
        .parity_err (parity_err),
        .clr_err    (clr_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic s);
        in_valid = 1'b1;
        in_bit   = b;
        in_sync  = s;
        tick();
        in_valid = 1'b0;
        in_bit   = 1'b0;
        in_sync  = 1'b0;
    endtask

    task automatic send_data(input logic [15:0] w, input int gap);
        for (int i = 0; i < 16; i++) begin
            send_bit(w[i], i == 0);
            if (i < 15) repeat (gap) tick();
        end
    endtask

    task automatic send_frame(input logic [15:0] w, input int gap);
        send_data(w, gap);
`ifdef DEMUX_PARITY_EN
        send_bit(^w, 1'b0);
`endif
    endtask

    task automatic clr_pulse();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    initial begin
        logic [15:0] partial;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        in_sync   = 1'b0;
        out_ready = 1'b1;
        clr_err   = 1'b0;

        vecs[0] = '{16'hA5C3, 0, 16'hA5C3};
        vecs[1] = '{16'h0000, 0, 16'h0000};
        vecs[2] = '{16'hFFFF, 2, 16'hFFFF};
        vecs[3] = '{16'h8001, 0, 16'h8001};
        vecs[4] = '{16'h5A0F, 1, 16'h5A0F};
        vecs[5] = '{16'h7FFE, 0, 16'h7FFE};

        repeat (2) tick();
        check("rst_out_word",   out_word,   16'h0000);
        check("rst_out_valid",  out_valid,  16'h0000);
        check("rst_ch_idx",     ch_idx,     16'h0000);
        check("rst_sync_err",   sync_err,   16'h0000);
        check("rst_overrun",    overrun,    16'h0000);
        check("rst_parity_err", parity_err, 16'h0000);
        rst_n = 1'b1;
        tick();

        // Clean frames with out_ready held high
        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].word, vecs[v].gap);
            check("tbl_out_valid",  out_valid,  16'h0001);
            check("tbl_out_word",   out_word,   vecs[v].exp_word);
            check("tbl_sync_err",   sync_err,   16'h0000);
            check("tbl_overrun",    overrun,    16'h0000);
            check("tbl_parity_err", parity_err, 16'h0000);
            check("tbl_ch_idx",     ch_idx,     16'h0000);
            tick();
            check("tbl_valid_drop", out_valid,  16'h0000);
        end

        // Back-to-back frames with a stalled consumer
        out_ready = 1'b0;
        send_frame(16'h1234, 0);
        check("ovr_first_valid", out_valid, 16'h0001);
        send_frame(16'hFFFF, 0);
        check("ovr_word_held",   out_word,  16'h1234);
        check("ovr_flag",        overrun,   16'h0001);
        check("ovr_valid_held",  out_valid, 16'h0001);
        out_ready = 1'b1;
        tick();
        check("ovr_valid_drop",  out_valid, 16'h0000);
        check("ovr_word_after",  out_word,  16'h1234);
        clr_pulse();
        check("ovr_cleared",     overrun,   16'h0000);

        // Early sync at count 7
        partial = 16'hBEEF;
        for (int i = 0; i < 7; i++) send_bit(partial[i], i == 0);
        check("early_ch_idx",   ch_idx,    16'h0007);
        check("early_no_valid", out_valid, 16'h0000);
        send_frame(16'h00F0, 0);
        check("early_sync_err", sync_err,  16'h0001);
        check("early_word",     out_word,  16'h00F0);
        check("early_valid",    out_valid, 16'h0001);
        tick();
        clr_pulse();
        check("early_cleared",  sync_err,  16'h0000);

        // Missing sync after a completed frame falls back to HUNT
        send_bit(1'b1, 1'b0);
        check("align_sync_err", sync_err,  16'h0001);
        check("align_ch_idx",   ch_idx,    16'h0000);
        clr_pulse();
        check("align_cleared",  sync_err,  16'h0000);
        send_bit(1'b1, 1'b0);
        check("hunt_silent",    sync_err,  16'h0000);
        send_frame(16'h8001, 0);
        check("hunt_word",      out_word,  16'h8001);
        check("hunt_valid",     out_valid, 16'h0001);
        check("hunt_sync_err",  sync_err,  16'h0000);
        tick();

        // Asynchronous reset in the middle of a frame
        out_ready = 1'b0;
        send_frame(16'h3C3C, 0);
        check("arst_pre_word",  out_word,  16'h3C3C);
        for (int i = 0; i < 9; i++) send_bit(1'b1, i == 0);
        check("arst_ch_idx9",   ch_idx,    16'h0009);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_word",      out_word,  16'h0000);
        check("arst_valid",     out_valid, 16'h0000);
        check("arst_ch_idx",    ch_idx,    16'h0000);
        check("arst_sync_err",  sync_err,  16'h0000);
        check("arst_overrun",   overrun,   16'h0000);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        send_frame(16'h5555, 0);
        check("arst_new_word",  out_word,  16'h5555);
        check("arst_new_valid", out_valid, 16'h0001);
        tick();
        check("arst_new_drop",  out_valid, 16'h0000);

`ifdef DEMUX_PARITY_EN
        // Parity bit 0 on a single-one frame is a mismatch; 1 is correct
        send_data(16'h0001, 0);
        send_bit(1'b0, 1'b0);
        check("par_bad_valid",  out_valid,  16'h0000);
        check("par_bad_flag",   parity_err, 16'h0001);
        check("par_bad_ovr",    overrun,    16'h0000);
        send_data(16'h0001, 0);
        send_bit(1'b1, 1'b0);
        check("par_ok_valid",   out_valid,  16'h0001);
        check("par_ok_word",    out_word,   16'h0001);
        tick();
        clr_pulse();
        check("par_cleared",    parity_err, 16'h0000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
